fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
Instruction-fetch stage that sits directly upstream of the decode/execute datapath.
- Owns the fetch PC and drives the instruction-memory address.
- Buffers fetched instructions, each paired with its PC, in a small FIFO.
- Hands instructions to decode with a valid/ready handshake.
- Accepts a branch/jump redirect from the execute stage (taken-branch target); a redirect flushes all queued wrong-path instructions.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2.
RESET_PC, 64'h0, fetch PC loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
imem_addr  out  64  fetch address to instruction memory; equals fetch_pc.
imem_rdata  in  32  instruction word at imem_addr, combinational same-cycle read.
imem_req  out  1  high in cycles where imem_rdata is captured (push).
id_valid  out  1  queue head valid.
id_ready  in  1  decode accepts head this cycle.
id_instr  out  32  head instruction.
id_pc  out  64  PC of head instruction.
redirect_valid  in  1  taken branch/jump; flush and refetch.
redirect_pc  in  64  new fetch address.
occupancy  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
Reset
- While reset=0: fetch_pc=RESET_PC, rd/wr pointers=0, count=0.
- Outputs during reset: id_valid=0, id_instr=0, id_pc=0, imem_req=0, occupancy=0.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

Handshake and push/pop
- pop = id_valid & id_ready.
- push = ~redirect_valid & (count<DEPTH | pop).
- A push writes {fetch_pc, imem_rdata} at wr_ptr, then increments fetch_pc by 4 (wraps modulo 2^64).
- imem_req = push; imem_addr = fetch_pc at all times.
- id_valid = (count!=0).
- id_instr/id_pc are the head entry, read combinationally from storage.
- When empty, id_instr and id_pc hold the last written head-slot contents. They are don't-care; the bench must not check them.
- Pointers wrap modulo DEPTH.
- Count update: count += push - pop.
- Simultaneous push and pop when full is legal; count stays at DEPTH.
- Simultaneous push and pop when empty cannot occur (pop needs id_valid).

Latency
- Instruction fetched in cycle N is presented on id_* in cycle N+1 if the queue ahead of it is empty.
- First id_valid occurs one cycle after reset deassertion.

Redirect (priority over push/pop)
- At the edge with redirect_valid=1:
  - count, rd_ptr and wr_ptr are set to 0;
  - fetch_pc = {redirect_pc[63:2], 2'b00} (misaligned low bits forced to zero);
  - no push occurs.
- A pop in the same cycle is still a consumption by decode; the queue simply clears and no entry survives.
- Next cycle: id_valid=0, and imem_addr shows the new PC with imem_req=1.
- Back-to-back redirects: each one re-flushes; the last one wins.

Invariants
- occupancy never exceeds DEPTH.
- id_valid never rises without a prior push.
- Entries leave in strict fetch order.

Optional Feature:
PREFETCH_STATS_EN
- Defined: adds outputs stat_fetched (32, counts pushes) and stat_flushes (32, counts redirect cycles in which count!=0 or push would otherwise have occurred).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - Both update on the same edge as the event.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, id_ready=1, imem returns addr-dependent word 32'h0000_0013+addr → id_pc sequence 0,4,8,C on consecutive cycles starting one cycle after release, with id_instr matching each address.
- id_ready=0 for 8 cycles → occupancy climbs 1..4 and holds at 4; imem_req=0 once full; fetch_pc frozen at 0x10; on id_ready=1 the PCs emerge 0,4,8,C in order.
- Full queue with id_ready=1 continuously → imem_req=1 every cycle and occupancy stays 4 (simultaneous push/pop at full).
- Redirect to 0x103 while holding 3 entries → next cycle id_valid=0, occupancy=0, imem_addr=0x100; first delivered id_pc=0x100.
- Redirect with id_ready=1 in the same cycle, then a second redirect to 0x200 the following cycle → no stale entries delivered; first id_pc=0x200.
- Reset asserted asynchronously mid-cycle with 2 entries queued → outputs zero without waiting for a clock edge, and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode handshake, redirect and occupancy.
// PREFETCH_STATS_EN adds the stat_fetched / stat_flushes counter outputs.
interface fetch_prefetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [63:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic             imem_req;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_instr;
    logic [63:0]      id_pc;
    logic             redirect_valid;
    logic [63:0]      redirect_pc;
    logic [CNT_W-1:0] occupancy;
`ifdef PREFETCH_STATS_EN
    logic [31:0]      stat_fetched;
    logic [31:0]      stat_flushes;
`else
`endif

    // Environment side: memory, decode and execute stage
    modport master (
        output imem_rdata, id_ready, redirect_valid, redirect_pc,
`ifdef PREFETCH_STATS_EN
        input  stat_fetched, stat_flushes,
`endif
        input  imem_addr, imem_req, id_valid, id_instr, id_pc, occupancy
    );

    // Fetch stage side
    modport slave (
        input  imem_rdata, id_ready, redirect_valid, redirect_pc,
`ifdef PREFETCH_STATS_EN
        output stat_fetched, stat_flushes,
`endif
        output imem_addr, imem_req, id_valid, id_instr, id_pc, occupancy
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: owns the fetch PC and queues {pc, instr} pairs for decode.
// Optional macro PREFETCH_STATS_EN adds saturating fetch / flush statistics counters.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_prefetch_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [63:0]      fetch_pc;
    logic [31:0]      instr_mem [DEPTH];
    logic [63:0]      pc_mem    [DEPTH];
    logic             push;
    logic             pop;

    // Push is gated by reset so imem_req stays low while the stage is held in reset
    always_comb begin
        pop  = (count != '0) & bus.id_ready;
        push = reset & ~bus.redirect_valid & ((count < CNT_W'(DEPTH)) | pop);
    end

    assign bus.imem_addr = fetch_pc;
    assign bus.imem_req  = push;
    assign bus.id_valid  = (count != '0);
    assign bus.id_instr  = instr_mem[rd_ptr];
    assign bus.id_pc     = pc_mem[rd_ptr];
    assign bus.occupancy = count;

    // Queue storage is cleared by reset so the head reads zero while reset is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

    // Redirect flushes the queue and overrides any push or pop in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= {bus.redirect_pc[63:2], 2'b00};
        end else begin
            if (push) begin
                wr_ptr   <= PTR_W'(wr_ptr + 1'b1);
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            case ({push, pop})
                2'b10:   count <= CNT_W'(count + 1'b1);
                2'b01:   count <= CNT_W'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

`ifdef PREFETCH_STATS_EN
    logic flush_evt;

    always_comb begin
        flush_evt = bus.redirect_valid & ((count != '0) | (count < CNT_W'(DEPTH)) | pop);
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.stat_fetched <= '0;
            bus.stat_flushes <= '0;
        end else begin
            if (push && (bus.stat_fetched != 32'hFFFF_FFFF)) begin
                bus.stat_fetched <= bus.stat_fetched + 32'd1;
            end
            if (flush_evt && (bus.stat_flushes != 32'hFFFF_FFFF)) begin
                bus.stat_flushes <= bus.stat_flushes + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not present in this build.
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed scenarios then random traffic,
// all compared against a queue-based reference model of the fetch stage.
module tb_fetch_prefetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: word is a simple function of the address
    assign bus.imem_rdata = 32'h0000_0013 + bus.imem_addr[31:0];

    ent_t        mq[$];
    logic [63:0] mpc;
    int          n_checks = 0;
    int          n_fail   = 0;
`ifdef PREFETCH_STATS_EN
    logic [31:0] m_fetched;
    logic [31:0] m_flushes;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = RESET_PC;
`ifdef PREFETCH_STATS_EN
        m_fetched = '0;
        m_flushes = '0;
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_id_valid"},  64'(bus.id_valid),  64'd0);
        check({tag, "_id_instr"},  64'(bus.id_instr),  64'd0);
        check({tag, "_id_pc"},     bus.id_pc,          64'd0);
        check({tag, "_imem_req"},  64'(bus.imem_req),  64'd0);
        check({tag, "_occupancy"}, 64'(bus.occupancy), 64'd0);
        check({tag, "_imem_addr"}, bus.imem_addr,      RESET_PC);
    endtask

    // One clock: drive inputs, check outputs against the model, advance model at the edge
    task automatic do_cycle(input logic rdy, input logic rv, input logic [63:0] rpc);
        bit   valid;
        bit   pop;
        bit   push;
        ent_t e;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        valid = (mq.size() != 0);
        pop   = valid && rdy;
        push  = !rv && ((mq.size() < DEPTH) || pop);
        check("id_valid",  64'(bus.id_valid),  64'(valid));
        check("occupancy", 64'(bus.occupancy), 64'(mq.size()));
        check("imem_addr", bus.imem_addr,      mpc);
        check("imem_req",  64'(bus.imem_req),  64'(push));
        if (valid) begin
            check("id_pc",    bus.id_pc,          mq[0].pc);
            check("id_instr", 64'(bus.id_instr), 64'(mq[0].instr));
        end
`ifdef PREFETCH_STATS_EN
        check("stat_fetched", 64'(bus.stat_fetched), 64'(m_fetched));
        check("stat_flushes", 64'(bus.stat_flushes), 64'(m_flushes));
`endif
        @(posedge clk);
        if (rv) begin
            mq.delete();
            mpc = {rpc[63:2], 2'b00};
`ifdef PREFETCH_STATS_EN
            if (m_flushes != 32'hFFFF_FFFF) m_flushes++;
`endif
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc    = mpc;
                e.instr = 32'h0000_0013 + mpc[31:0];
                mq.push_back(e);
                mpc = mpc + 64'd4;
`ifdef PREFETCH_STATS_EN
                if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
`endif
            end
        end
        #1;
    endtask

    initial begin
        reset              = 1'b0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        model_reset();
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming: PCs 0,4,8,C from one cycle after release
        repeat (6) do_cycle(1'b1, 1'b0, 64'h0);

        // Back-pressure from a fresh start at PC 0: queue fills and fetch freezes at 0x10
        do_cycle(1'b1, 1'b1, 64'h0);
        repeat (8) do_cycle(1'b0, 1'b0, 64'h0);
        check("full_occupancy", 64'(bus.occupancy), 64'd4);
        check("frozen_pc",      bus.imem_addr,      64'h10);
        check("full_no_req",    64'(bus.imem_req),  64'd0);

        // Drain with continuous ready: push and pop together at full
        repeat (8) do_cycle(1'b1, 1'b0, 64'h0);

        // Redirect to a misaligned target while holding 3 entries
        do_cycle(1'b1, 1'b1, 64'h40);
        repeat (3) do_cycle(1'b0, 1'b0, 64'h0);
        check("three_held", 64'(bus.occupancy), 64'd3);
        do_cycle(1'b0, 1'b1, 64'h103);
        check("redir_addr",  bus.imem_addr,      64'h100);
        check("redir_valid", 64'(bus.id_valid),  64'd0);
        repeat (4) do_cycle(1'b1, 1'b0, 64'h0);

        // Redirect with a same-cycle pop, then a second redirect: last one wins
        do_cycle(1'b1, 1'b1, 64'h300);
        do_cycle(1'b1, 1'b1, 64'h200);
        check("redir2_addr", bus.imem_addr, 64'h200);
        repeat (4) do_cycle(1'b1, 1'b0, 64'h0);

        // Asynchronous reset mid-cycle with 2 entries queued
        do_cycle(1'b0, 1'b1, 64'h500);
        repeat (2) do_cycle(1'b0, 1'b0, 64'h0);
        check("two_held", 64'(bus.occupancy), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        reset = 1'b1;
        repeat (5) do_cycle(1'b1, 1'b0, 64'h0);

        // Random traffic: stalls and occasional redirects to arbitrary targets
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 15) == 0),
                     {$urandom(), $urandom()});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
